tmr_fault_monitor: RTL

Sequential fault manager that sits directly downstream of the TMR voter in the triple-core RISC-V. Each cycle it consumes the voter's pairwise agreement flags, identifies the odd core out, and filters transient upsets from persistent faults. A persistently faulty core is reset and resynchronised with the pipeline stalled, and is retired after repeated failures. It raises a sticky fatal flag when no majority exists.

---
 rtl/tmr_pkg.sv | 46 ++++
 rtl/tmr_sat_counter.sv | 21 ++
 rtl/tmr_fault_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared types and sample classification for the TMR fault monitor.
package tmr_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SUSPECT = 2'd1,
        RECOVER = 2'd2,
        FATAL   = 2'd3
    } state_t;

    localparam logic [1:0] CORE_A    = 2'b00;
    localparam logic [1:0] CORE_B    = 2'b01;
    localparam logic [1:0] CORE_C    = 2'b10;
    localparam logic [1:0] CORE_NONE = 2'b11;

    typedef enum logic [2:0] {
        CL_CLEAN = 3'd0,
        CL_ODD_A = 3'd1,
        CL_ODD_B = 3'd2,
        CL_ODD_C = 3'd3,
        CL_NOMAJ = 3'd4
    } class_t;

    // cmp = {AB, BC, AC}; with one core retired only the surviving pair counts.
    function automatic class_t classify(input logic [2:0] cmp, input logic [2:0] dis);
        class_t c;
        c = CL_NOMAJ;
        case (dis)
            3'b000: begin
                case (cmp)
                    3'b111:  c = CL_CLEAN;
                    3'b010:  c = CL_ODD_A;
                    3'b001:  c = CL_ODD_B;
                    3'b100:  c = CL_ODD_C;
                    default: c = CL_NOMAJ;
                endcase
            end
            3'b001:  c = cmp[1] ? CL_CLEAN : CL_NOMAJ;
            3'b010:  c = cmp[0] ? CL_CLEAN : CL_NOMAJ;
            3'b100:  c = cmp[2] ? CL_CLEAN : CL_NOMAJ;
            default: c = CL_NOMAJ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// Saturating up-counter used for the fault statistics.
module tmr_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Fault manager behind the TMR voter: isolates the odd core, recovers or retires it,
// and latches fatal on loss of majority.
module tmr_fault_monitor
    import tmr_pkg::*;
#(
    parameter int unsigned PERSIST       = 4,
    parameter int unsigned RESYNC_CYCLES = 8,
    parameter int unsigned MAX_RECOV     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_valid,
    input  logic [2:0]       cmp,
    output logic [2:0]       core_rst_n,
    output logic [2:0]       core_disable,
    output logic             stall,
    output logic [1:0]       fault_core,
    output logic             resync_done,
    output logic             fatal,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c,
    output logic [CNT_W-1:0] transient_cnt
);

    localparam int unsigned PW = $clog2(PERSIST + 1);
    localparam int unsigned RW = (MAX_RECOV > 0) ? $clog2(MAX_RECOV + 1) : 1;
    localparam int unsigned TW = $clog2(RESYNC_CYCLES + 1);

    state_t          state;
    logic [PW-1:0]   persist;
    logic [RW-1:0]   recov_cnt [3];
    logic [TW-1:0]   resync_left;

    class_t          cls;
    logic            sample;
    logic            is_odd;
    logic [1:0]      odd_id;
    logic [RW-1:0]   odd_recov;
    logic [PW-1:0]   p_new;
    logic            p_hit;
    logic [2:0]      inc_err;
    logic            inc_trans;

    assign cls    = classify(cmp, core_disable);
    assign sample = cmp_valid && ((state == NORMAL) || (state == SUSPECT));

    always_comb begin
        odd_id    = CORE_NONE;
        odd_recov = '0;
        case (cls)
            CL_ODD_A: begin odd_id = CORE_A; odd_recov = recov_cnt[0]; end
            CL_ODD_B: begin odd_id = CORE_B; odd_recov = recov_cnt[1]; end
            CL_ODD_C: begin odd_id = CORE_C; odd_recov = recov_cnt[2]; end
            default:  begin odd_id = CORE_NONE; odd_recov = '0; end
        endcase
    end

    assign is_odd = (odd_id != CORE_NONE);
    // persist restarts at 1 whenever the suspected core changes or we come from NORMAL
    assign p_new  = ((state == SUSPECT) && (fault_core == odd_id)) ? (persist + PW'(1)) : PW'(1);
    assign p_hit  = (p_new == PW'(PERSIST));

    assign inc_err[0] = sample && (odd_id == CORE_A);
    assign inc_err[1] = sample && (odd_id == CORE_B);
    assign inc_err[2] = sample && (odd_id == CORE_C);
    assign inc_trans  = sample && (state == SUSPECT) && (cls == CL_CLEAN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= NORMAL;
            persist      <= '0;
            resync_left  <= '0;
            core_rst_n   <= 3'b111;
            core_disable <= '0;
            stall        <= 1'b0;
            fault_core   <= CORE_NONE;
            resync_done  <= 1'b0;
            fatal        <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) recov_cnt[i] <= '0;
        end else begin
            resync_done <= 1'b0;
            case (state)
                NORMAL, SUSPECT: begin
                    if (cmp_valid) begin
                        if (cls == CL_CLEAN) begin
                            state      <= NORMAL;
                            fault_core <= CORE_NONE;
                            persist    <= '0;
                        end else if (!is_odd) begin
                            state <= FATAL;
                            fatal <= 1'b1;
                            stall <= 1'b1;
                        end else if (!p_hit) begin
                            state      <= SUSPECT;
                            fault_core <= odd_id;
                            persist    <= p_new;
                        end else if (odd_recov == RW'(MAX_RECOV)) begin
                            core_disable[odd_id] <= 1'b1;
                            core_rst_n[odd_id]   <= 1'b0;
                            state                <= NORMAL;
                            fault_core           <= CORE_NONE;
                            persist              <= '0;
                        end else begin
                            core_rst_n[odd_id] <= 1'b0;
                            stall              <= 1'b1;
                            state              <= RECOVER;
                            fault_core         <= odd_id;
                            persist            <= '0;
                            resync_left        <= TW'(RESYNC_CYCLES - 1);
                        end
                    end
                end
                RECOVER: begin
                    if (resync_left == '0) begin
                        core_rst_n[fault_core] <= 1'b1;
                        recov_cnt[fault_core]  <= recov_cnt[fault_core] + RW'(1);
                        stall                  <= 1'b0;
                        resync_done            <= 1'b1;
                        state                  <= NORMAL;
                        fault_core             <= CORE_NONE;
                    end else begin
                        resync_left <= resync_left - TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    tmr_sat_counter #(.W(CNT_W)) u_err_a (.clk(clk), .rst(rst), .inc(inc_err[0]), .q(err_cnt_a));
    tmr_sat_counter #(.W(CNT_W)) u_err_b (.clk(clk), .rst(rst), .inc(inc_err[1]), .q(err_cnt_b));
    tmr_sat_counter #(.W(CNT_W)) u_err_c (.clk(clk), .rst(rst), .inc(inc_err[2]), .q(err_cnt_c));
    tmr_sat_counter #(.W(CNT_W)) u_trans (.clk(clk), .rst(rst), .inc(inc_trans),  .q(transient_cnt));

endmodule
